result_display: RTL and testbench

Consumer side of the calculator's 16-bit result register. It samples the registered result on a load strobe and converts it to four decimal digits with a sequential double-dabble engine, one iteration per cycle. It then time-multiplexes the digits onto a 4-digit common-anode seven-segment display. It sits between the result register and the board display pins.

---
 rtl/calc_disp_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/result_display.sv | 156 +++++++++++++++
 tb/tb_result_display.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display.
// Holds the FSM encoding, datapath widths, segment codes and the dabble step.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam int N_DIGITS = 4;
  localparam int BIN_W    = 16;
  localparam int BCD_W    = 20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern (seg[0]=a .. seg[6]=g).
// Non-decimal inputs produce a blank digit.
module seg7_decode
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Samples the result register on load, converts it to BCD with a one-iteration-per-cycle
// double-dabble engine and scans the digits onto a 4-digit common-anode display.
module result_display
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] result,
  output logic        busy,
  output logic        valid,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   commit;
  logic                   tick;
  logic [3:0]             blank;
  logic [3:0]             cur_nib;
  logic [6:0]             dec_seg;

  // FSM and double-dabble datapath.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    commit  = 1'b0;
    bcd_adj = dabble_adjust(bcd_q);
    shifted = {bcd_adj, bin_q} << 1;
    case (state_q)
      IDLE, SHOW: begin
        if (load) begin
          bin_d   = result;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          commit  = 1'b1;
          disp_d  = shifted[BIN_W+15:BIN_W];
          ovf_d   = |shifted[BCD_W+BIN_W-1:BIN_W+16];
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan divider, digit index and leading-zero blanking, evaluated on the next-state view
  // so that a commit and a tick on the same edge show the new digits at the new index.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    blank[3] = (disp_d[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_d[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_d[7:4] == 4'd0);
    blank[0] = 1'b0;

    case (idx_d)
      2'd0:    cur_nib = disp_d[3:0];
      2'd1:    cur_nib = disp_d[7:4];
      2'd2:    cur_nib = disp_d[11:8];
      default: cur_nib = disp_d[15:12];
    endcase

    an_d  = an_q;
    seg_d = seg_q;
    if (tick || commit) begin
      an_d = valid_d ? ~(4'b0001 << idx_d) : 4'b1111;
      if (!valid_d || blank[idx_d]) begin
        seg_d = SEG_BLANK;
      end else if (ovf_d) begin
        seg_d = SEG_DASH;
      end else begin
        seg_d = dec_seg;
      end
      if (valid_d && ovf_d) begin
        seg_d = SEG_DASH;
      end
    end
  end

  seg7_decode u_decode (
    .bcd (cur_nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy  = (state_q == CONVERT);
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display with a fast scan (REFRESH_DIV=4).
// Expected digit patterns are queued at each accepted load and popped at the commit.
module tb_result_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] result;
  logic        busy;
  logic        valid;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  // {ovf, seg3, seg2, seg1, seg0}
  logic [28:0] exp_q[$];
  logic [28:0] last_exp;

  result_display #(.REFRESH_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .result (result),
    .busy   (busy),
    .valid  (valid),
    .ovf    (ovf),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [28:0] exp_of(input int v);
    logic [28:0] e;
    int pow;
    e[28] = (v > 9999);
    pow = 1;
    for (int i = 0; i < 4; i++) begin
      if (v > 9999)                e[i*7 +: 7] = 7'b0111111;
      else if (i > 0 && v < pow)   e[i*7 +: 7] = 7'b1111111;
      else                         e[i*7 +: 7] = seg_of((v / pow) % 10);
      pow = pow * 10;
    end
    return e;
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic start_load(input logic [15:0] v);
    @(negedge clk);
    result = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Loads v, optionally fires a second load on the inject_at-th busy cycle, then checks
  // the busy length, the commit flags and a full scan against the scoreboard.
  task automatic convert_and_check(input int v, input int inject_at, input int inj_v);
    int n;
    int idx;
    logic [28:0] e;
    logic [3:0] seen;
    exp_q.push_back(exp_of(v));
    start_load(16'(v));
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == inject_at) begin
        load   = 1'b1;
        result = 16'(inj_v);
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL busy_len v=%0d got %0d want 16", v, n);
    end
    checks++;
    if (valid !== 1'b1 || ovf !== e[28]) begin
      errors++;
      $display("FAIL commit_flags v=%0d got valid=%b ovf=%b want valid=1 ovf=%b", v, valid, ovf, e[28]);
    end
    seen = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      idx = idx_of(an);
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL scan_an v=%0d got an=%b want one-hot-low", v, an);
      end else begin
        seen[idx] = 1'b1;
        checks++;
        if (seg !== e[idx*7 +: 7]) begin
          errors++;
          $display("FAIL scan_seg v=%0d digit=%0d got %b want %b", v, idx, seg, e[idx*7 +: 7]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen !== 4'hF || dp !== 1'b1) begin
      errors++;
      $display("FAIL scan_cover v=%0d got seen=%b dp=%b want 1111 dp=1", v, seen, dp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0 || an !== 4'b1111 ||
        seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL %s got busy=%b valid=%b ovf=%b an=%b seg=%b dp=%b want 0 0 0 1111 1111111 1",
               tag, busy, valid, ovf, an, seg, dp);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    load   = 1'b0;
    result = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_initial");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_reset_values("idle_after_release");
    // Reset during a conversion discards it.
    exp_q.push_back(exp_of(1234));
    start_load(16'd1234);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_convert");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || an !== 4'b1111) begin
        errors++;
        $display("FAIL post_reset c=%0d got busy=%b valid=%b an=%b want 0 0 1111", c, busy, valid, an);
      end
    end
  endtask

  task automatic test_basic;
    convert_and_check(1234, 0, 0);
    convert_and_check(5678, 0, 0);
    convert_and_check($urandom_range(0, 9999), 0, 0);
  endtask

  task automatic test_blanking;
    convert_and_check(42, 0, 0);
    convert_and_check(0, 0, 0);
    convert_and_check(907, 0, 0);
  endtask

  task automatic test_overflow;
    convert_and_check(10000, 0, 0);
    convert_and_check(65535, 0, 0);
    convert_and_check(9999, 0, 0);
  endtask

  task automatic test_load_busy;
    convert_and_check(1234, 5, 9999);
  endtask

  task automatic test_reload;
    logic [28:0] old_e;
    logic [28:0] e;
    int n;
    int idx;
    old_e = last_exp;
    exp_q.push_back(exp_of(42));
    start_load(16'd42);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      idx = idx_of(an);
      checks++;
      if (idx < 0 || seg !== old_e[idx*7 +: 7]) begin
        errors++;
        $display("FAIL reload_hold n=%0d got an=%b seg=%b want old digits", n, an, seg);
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reload_busy_len got %0d want 16", n);
    end
    idx = idx_of(an);
    checks++;
    if (idx < 0 || seg !== e[idx*7 +: 7] || valid !== 1'b1) begin
      errors++;
      $display("FAIL reload_commit got an=%b seg=%b valid=%b want new digits", an, seg, valid);
    end
  endtask

  initial begin
    last_exp = '0;
    test_reset();
    test_basic();
    test_blanking();
    test_overflow();
    test_load_busy();
    test_reload();
    convert_and_check(1234, 0, 0);
    test_reload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
